// File: rtl/md_issue.sv
// Issue stage for a multiply/divide unit: stalls decode while the unit is busy or an op is in flight.
// Optional divide-by-zero trap enabled by defining MD_ISSUE_DIV0_TRAP_EN.
module md_issue #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [3:0]       op_class,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic             flush,
  input  logic             md_busy,
  output logic [3:0]       alu_class,
  output logic [31:0]      D1,
  output logic [31:0]      D2,
  output logic             stall,
  output logic             div0,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e state_q;

  logic is_md;
  logic is_hl;
  logic accept;
  logic trap;
  logic issue;

  always_comb begin
    is_md  = (op_class >= 4'd1) && (op_class <= 4'd4);
    is_hl  = (op_class >= 4'd5) && (op_class <= 4'd8);
    stall  = op_valid && !flush && (is_md || is_hl) && ((state_q != StIdle) || md_busy);
    accept = op_valid && !flush && !stall && (is_md || is_hl);
`ifdef MD_ISSUE_DIV0_TRAP_EN
    trap   = accept && ((op_class == 4'd3) || (op_class == 4'd4)) && (rt_val == 32'd0);
`else
    trap   = 1'b0;
`endif
    issue  = accept && !trap;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      alu_class <= 4'd0;
      D1        <= 32'd0;
      D2        <= 32'd0;
      div0      <= 1'b0;
      stall_cnt <= '0;
    end else begin
      // alu_class is a one-cycle start strobe; it clears unless a new op is issued
      alu_class <= issue ? op_class : 4'd0;
      div0      <= trap;
      if (issue) begin
        D1 <= rs_val;
        D2 <= rt_val;
      end
      if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (issue && is_md) begin
            state_q <= StIssue;
          end
        end
        // md_busy is not yet valid for the op just issued
        StIssue: state_q <= StWait;
        StWait: begin
          if (!md_busy) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_md_issue.sv
// Directed bench for md_issue: vector table from a fresh reset plus multi-cycle sequences.
// Expectations follow MD_ISSUE_DIV0_TRAP_EN when it is defined.
module tb_md_issue;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic [3:0]  op_class;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        md_busy;

  logic [3:0]  alu_class;
  logic [31:0] D1;
  logic [31:0] D2;
  logic        stall;
  logic        div0;
  logic [15:0] stall_cnt;

  logic [3:0]  alu_class4;
  logic [31:0] D1_4;
  logic [31:0] D2_4;
  logic        stall4;
  logic        div0_4;
  logic [3:0]  stall_cnt4;

  int checks;
  int failures;

  md_issue #(.CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_class  (op_class),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .flush     (flush),
    .md_busy   (md_busy),
    .alu_class (alu_class),
    .D1        (D1),
    .D2        (D2),
    .stall     (stall),
    .div0      (div0),
    .stall_cnt (stall_cnt)
  );

  md_issue #(.CNT_W(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_class  (op_class),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .flush     (flush),
    .md_busy   (md_busy),
    .alu_class (alu_class4),
    .D1        (D1_4),
    .D2        (D2_4),
    .stall     (stall4),
    .div0      (div0_4),
    .stall_cnt (stall_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [3:0]  cls;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        fl;
    logic        busy;
    logic        e_stall;
    logic [3:0]  e_cls;
    logic [31:0] e_d1;
    logic [31:0] e_d2;
    logic        e_div0;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs[NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] rs,
                       input logic [31:0] rt, input logic f, input logic b);
    op_valid = v;
    op_class = c;
    rs_val   = rs;
    rt_val   = rt;
    flush    = f;
    md_busy  = b;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // {valid, class, rs, rt, flush, busy, exp stall, exp class, exp D1, exp D2, exp div0}
    vecs[0]  = '{1'b1, 4'd1, 32'd7, 32'hFFFFFFFD, 1'b0, 1'b0,
                 1'b0, 4'd1, 32'd7, 32'hFFFFFFFD, 1'b0};
    vecs[1]  = '{1'b1, 4'd7, 32'h1234, 32'h5678, 1'b1, 1'b0,
                 1'b0, 4'd0, 32'd0, 32'd0, 1'b0};
    vecs[2]  = '{1'b1, 4'd7, 32'h1234, 32'h5678, 1'b0, 1'b0,
                 1'b0, 4'd7, 32'h1234, 32'h5678, 1'b0};
    vecs[3]  = '{1'b1, 4'd0, 32'hAA, 32'hBB, 1'b0, 1'b1,
                 1'b0, 4'd0, 32'd0, 32'd0, 1'b0};
    vecs[4]  = '{1'b1, 4'd9, 32'hAA, 32'hBB, 1'b0, 1'b1,
                 1'b0, 4'd0, 32'd0, 32'd0, 1'b0};
    vecs[5]  = '{1'b1, 4'd15, 32'hAA, 32'hBB, 1'b0, 1'b0,
                 1'b0, 4'd0, 32'd0, 32'd0, 1'b0};
    vecs[6]  = '{1'b1, 4'd2, 32'h11, 32'h22, 1'b0, 1'b1,
                 1'b1, 4'd0, 32'd0, 32'd0, 1'b0};
    vecs[7]  = '{1'b0, 4'd1, 32'h11, 32'h22, 1'b0, 1'b0,
                 1'b0, 4'd0, 32'd0, 32'd0, 1'b0};
    vecs[8]  = '{1'b1, 4'd6, 32'h33, 32'h44, 1'b0, 1'b1,
                 1'b1, 4'd0, 32'd0, 32'd0, 1'b0};
`ifdef MD_ISSUE_DIV0_TRAP_EN
    vecs[9]  = '{1'b1, 4'd4, 32'd9, 32'd0, 1'b0, 1'b0,
                 1'b0, 4'd0, 32'd0, 32'd0, 1'b1};
`else
    vecs[9]  = '{1'b1, 4'd4, 32'd9, 32'd0, 1'b0, 1'b0,
                 1'b0, 4'd4, 32'd9, 32'd0, 1'b0};
`endif
    vecs[10] = '{1'b1, 4'd3, 32'd100, 32'd5, 1'b0, 1'b0,
                 1'b0, 4'd3, 32'd100, 32'd5, 1'b0};
    vecs[11] = '{1'b1, 4'd8, 32'hDEAD, 32'hBEEF, 1'b1, 1'b1,
                 1'b0, 4'd0, 32'd0, 32'd0, 1'b0};

    #12;
    chk("rst_alu_class", {28'd0, alu_class}, 32'd0);
    chk("rst_d1", D1, 32'd0);
    chk("rst_d2", D2, 32'd0);
    chk("rst_div0", {31'd0, div0}, 32'd0);
    chk("rst_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_stall_idle", {31'd0, stall}, 32'd0);
    reset = 1'b1;
    step();

    for (int i = 0; i < NVEC; i++) begin
      pulse_reset();
      drive(vecs[i].valid, vecs[i].cls, vecs[i].rs, vecs[i].rt, vecs[i].fl, vecs[i].busy);
      #1;
      chk($sformatf("vec%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].e_stall});
      step();
      chk($sformatf("vec%0d_class", i), {28'd0, alu_class}, {28'd0, vecs[i].e_cls});
      chk($sformatf("vec%0d_d1", i), D1, vecs[i].e_d1);
      chk($sformatf("vec%0d_d2", i), D2, vecs[i].e_d2);
      chk($sformatf("vec%0d_div0", i), {31'd0, div0}, {31'd0, vecs[i].e_div0});
      drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      step();
      chk($sformatf("vec%0d_class_clear", i), {28'd0, alu_class}, 32'd0);
      chk($sformatf("vec%0d_div0_clear", i), {31'd0, div0}, 32'd0);
    end

    // mult then WAIT: operands hold, HL op stalls in WAIT, accepted once back in IDLE
    pulse_reset();
    drive(1'b1, 4'd1, 32'd7, 32'hFFFFFFFD, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'd0, 32'h99, 32'h88, 1'b0, 1'b0);
    step();
    chk("seqA_class0", {28'd0, alu_class}, 32'd0);
    chk("seqA_d1_hold", D1, 32'd7);
    chk("seqA_d2_hold", D2, 32'hFFFFFFFD);
    drive(1'b1, 4'd5, 32'h55, 32'h66, 1'b0, 1'b0);
    #1;
    chk("seqA_wait_stall", {31'd0, stall}, 32'd1);
    step();
    chk("seqA_idle_nostall", {31'd0, stall}, 32'd0);
    step();
    chk("seqA_mfhi_class", {28'd0, alu_class}, 32'd5);
    chk("seqA_mfhi_d1", D1, 32'h55);

    // second MD op in the ISSUE gap stalls even with md_busy low
    pulse_reset();
    drive(1'b1, 4'd1, 32'd1, 32'd2, 1'b0, 1'b0);
    step();
    drive(1'b1, 4'd2, 32'd3, 32'd4, 1'b0, 1'b0);
    #1;
    chk("seqB_issue_stall", {31'd0, stall}, 32'd1);
    step();
    chk("seqB_no_repeat", {28'd0, alu_class}, 32'd0);
    chk("seqB_d1_kept", D1, 32'd1);

    // div with md_busy high for 10 cycles starting in the ISSUE cycle, mfhi waiting behind it
    pulse_reset();
    drive(1'b1, 4'd3, 32'd100, 32'd7, 1'b0, 1'b0);
    step();
    chk("seqC_div_class", {28'd0, alu_class}, 32'd3);
    drive(1'b1, 4'd5, 32'h77, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("seqC_busy_stall%0d", k), {31'd0, stall}, 32'd1);
      step();
      if (k == 0) chk("seqC_class_one_cycle", {28'd0, alu_class}, 32'd0);
    end
    md_busy = 1'b0;
    #1;
    chk("seqC_wait_exit_stall", {31'd0, stall}, 32'd1);
    step();
    chk("seqC_accept_nostall", {31'd0, stall}, 32'd0);
    step();
    chk("seqC_mfhi_class", {28'd0, alu_class}, 32'd5);
    chk("seqC_mfhi_d1", D1, 32'h77);
    chk("seqC_stall_cnt", {16'd0, stall_cnt}, 32'd11);

`ifdef MD_ISSUE_DIV0_TRAP_EN
    // trapped divide leaves the FSM in IDLE
    pulse_reset();
    drive(1'b1, 4'd3, 32'd5, 32'd0, 1'b0, 1'b0);
    step();
    chk("seqD_div0_set", {31'd0, div0}, 32'd1);
    chk("seqD_class0", {28'd0, alu_class}, 32'd0);
    drive(1'b1, 4'd7, 32'd6, 32'd1, 1'b0, 1'b0);
    #1;
    chk("seqD_idle_nostall", {31'd0, stall}, 32'd0);
    step();
    chk("seqD_div0_clear", {31'd0, div0}, 32'd0);
    chk("seqD_mthi_class", {28'd0, alu_class}, 32'd7);
`endif

    // saturation: 20 stalled cycles, 4-bit counter pins at 15
    pulse_reset();
    drive(1'b1, 4'd1, 32'd1, 32'd1, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) step();
    chk("seqE_stall4", {31'd0, stall4}, 32'd1);
    chk("seqE_cnt4_sat", {28'd0, stall_cnt4}, 32'd15);
    chk("seqE_cnt16", {16'd0, stall_cnt}, 32'd20);

    // reset in WAIT: all outputs clear at once, stall stays live during reset
    drive(1'b1, 4'd1, 32'hC0DE, 32'hF00D, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    step();
    step();
    chk("seqF_d1_loaded", D1, 32'hC0DE);
    reset = 1'b0;
    #1;
    chk("seqF_rst_class", {28'd0, alu_class}, 32'd0);
    chk("seqF_rst_d1", D1, 32'd0);
    chk("seqF_rst_d2", D2, 32'd0);
    chk("seqF_rst_div0", {31'd0, div0}, 32'd0);
    chk("seqF_rst_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("seqF_rst_cnt4", {28'd0, stall_cnt4}, 32'd0);
    chk("seqF_rst_d1_4", D1_4, 32'd0);
    chk("seqF_rst_d2_4", D2_4, 32'd0);
    chk("seqF_rst_class4", {28'd0, alu_class4}, 32'd0);
    chk("seqF_rst_div0_4", {31'd0, div0_4}, 32'd0);
    drive(1'b1, 4'd1, 32'd1, 32'd1, 1'b0, 1'b1);
    #1;
    chk("seqF_stall_in_reset", {31'd0, stall}, 32'd1);
    step();
    reset = 1'b1;
    drive(1'b1, 4'd7, 32'h42, 32'h43, 1'b0, 1'b0);
    #1;
    chk("seqF_idle_after_release", {31'd0, stall}, 32'd0);
    step();
    chk("seqF_mthi_class", {28'd0, alu_class}, 32'd7);
    chk("seqF_mthi_d1", D1, 32'h42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
